// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state, owner encoding and default widths
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational grant selection, data first unless fetch is starved
//   in:  if_req, dm_req, starve_cnt
//   out: grant_valid, grant_owner
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CW = 1
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          grant_valid,
  output owner_t        grant_owner
);
  logic force_if;
  always_comb begin
    force_if = (STARVE_LIMIT != 0) && (starve_cnt == CW'(STARVE_LIMIT));
    grant_valid = if_req | dm_req;
    grant_owner = (dm_req && !(if_req && force_if)) ? OWN_DM : OWN_IF;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data stages
//   fetch:  if_req/if_addr in, if_ready pulse + if_rdata out
//   data:   dm_req/dm_we/dm_addr/dm_wdata in, dm_ready pulse + dm_rdata out
//   memory: mem_req/mem_we/mem_addr/mem_wdata out (held until mem_ack), mem_ack/mem_rdata in
//   MEM_ARB_PERF_EN adds perf_if_cnt, perf_dm_cnt, perf_conflict_cnt
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_if_cnt,
  output logic [31:0]   perf_dm_cnt,
  output logic [31:0]   perf_conflict_cnt
`endif
);
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          grant_valid, grant_now;
  owner_t        grant_owner;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_q),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  assign grant_now = (state_q == IDLE) && grant_valid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    case (state_q)
      IDLE: if (grant_valid) begin
        state_d     = BUSY;
        owner_d     = grant_owner;
        mem_req_d   = 1'b1;
        mem_we_d    = (grant_owner == OWN_DM) ? dm_we : 1'b0;
        mem_addr_d  = (grant_owner == OWN_DM) ? dm_addr : if_addr;
        mem_wdata_d = (grant_owner == OWN_DM) ? dm_wdata : '0;
        // saturating count of dm wins over a waiting fetch
        starve_d    = (grant_owner == OWN_IF) ? '0 :
                      (if_req && starve_q != LIM) ? starve_q + CW'(1) : starve_q;
      end
      BUSY: if (mem_ack) begin
        state_d    = RESP;
        mem_req_d  = 1'b0;
        if_ready_d = (owner_q == OWN_IF);
        dm_ready_d = (owner_q == OWN_DM);
        if_rdata_d = (owner_q == OWN_IF) ? mem_rdata : if_rdata_q;
        dm_rdata_d = (owner_q == OWN_DM && !mem_we_q) ? mem_rdata : dm_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d, perf_dm_q, perf_dm_d, perf_cf_q, perf_cf_d;
  always_comb begin
    perf_if_d = perf_if_q + ((grant_now && grant_owner == OWN_IF) ? 32'd1 : 32'd0);
    perf_dm_d = perf_dm_q + ((grant_now && grant_owner == OWN_DM) ? 32'd1 : 32'd0);
    perf_cf_d = perf_cf_q + ((state_q == IDLE && if_req && dm_req) ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
      perf_cf_q <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_dm_q <= perf_dm_d;
      perf_cf_q <= perf_cf_d;
    end
  end
  assign perf_if_cnt       = perf_if_q;
  assign perf_dm_cnt       = perf_dm_q;
  assign perf_conflict_cnt = perf_cf_q;
`else
  logic unused_grant_now;
  assign unused_grant_now = grant_now;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_cnt, perf_dm_cnt, perf_conflict_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic exp_dm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    tick();
    chk("t1_hold", mem_req, 1);
    chk("t1_no_ready", if_ready, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("t1_if_ready", if_ready, 1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_req_drop", mem_req, 0);
    chk("t1_dm_ready", dm_ready, 0);
    if_req = 1'b0;
    tick();
    chk("t1_ready_pulse", if_ready, 0);
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_addr = 32'h300;
    tick();
    chk("t2_dm_first", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'hA5A50300;
    tick();
    mem_ack = 1'b0;
    chk("t2_dm_ready", dm_ready, 1);
    chk("t2_if_not_ready", if_ready, 0);
    chk("t2_dm_rdata", dm_rdata, 32'hA5A50300);
    dm_req = 1'b0;
    tick();
    chk("t2_resp_gap", {dm_ready, if_ready, mem_req}, 0);
    tick();
    chk("t2_if_second", mem_addr, 32'h200);
    chk("t2_if_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD0200;
    tick();
    mem_ack = 1'b0;
    chk("t2_if_ready", if_ready, 1);
    chk("t2_dm_quiet", dm_ready, 0);
    chk("t2_if_rdata", if_rdata, 32'h0BAD0200);
    if_req = 1'b0;
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    tick();
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_wdata", mem_wdata, 32'h12345678);
    chk("t3_mem_addr", mem_addr, 32'h40);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    chk("t3_dm_ready", dm_ready, 1);
    chk("t3_dm_rdata_kept", dm_rdata, 32'hA5A50300);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack", {mem_req, if_ready, dm_ready}, 0);
    chk("stray_rdata", if_rdata, 32'h0BAD0200);
    if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_addr = 32'h600;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("starve_addr%0d", i), mem_addr, exp_dm[i] ? 32'h600 : 32'h500);
      mem_ack = 1'b1; mem_rdata = i;
      tick();
      mem_ack = 1'b0;
      chk($sformatf("starve_ready%0d", i), {dm_ready, if_ready}, exp_dm[i] ? 2'b10 : 2'b01);
      if (i == 5) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      tick();
    end
    if_req = 1'b1; if_addr = 32'h700;
    tick();
    chk("t5_busy", mem_req, 1);
`ifdef MEM_ARB_PERF_EN
    chk("perf_if", perf_if_cnt, 5);
    chk("perf_dm", perf_dm_cnt, 6);
    chk("perf_conflict", perf_conflict_cnt, 7);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t5_async_req", mem_req, 0);
    chk("t5_async_addr", mem_addr, 0);
    chk("t5_async_rdata", {if_rdata, dm_rdata}, 0);
    tick();
    chk("t5_no_ready", {if_ready, dm_ready}, 0);
    rst = 1'b0;
    tick();
    chk("t5_regrant", mem_addr, 32'h700);
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    chk("t5_if_ready", if_ready, 1);
    chk("t5_if_rdata", if_rdata, 32'h77);
    if_req = 1'b0;
    tick();
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_after_rst", perf_if_cnt, 1);
    chk("perf_conf_after_rst", perf_conflict_cnt, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
